stdp_weight_rmw_ctrl: RTL and testbench

Read-modify-write controller that owns both ports of the synaptic weight RAM in the STDP learning engine. It accepts weight-update requests (address, signed delta), reads the current weight through the RAM's registered read port, adds the delta with saturation, and writes the result back through the write port. The datapath is fully pipelined: one update per cycle, with read-after-write hazards on back-to-back updates resolved by forwarding.

---
 rtl/stdp_weight_rmw_ctrl.sv | 167 ++++++++++++++++
 tb/tb_stdp_weight_rmw_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stdp_weight_rmw_ctrl.sv
// Pipelined read-modify-write controller for the STDP synaptic weight RAM (accept -> E -> W).
// Define STDP_RMW_FWD_EN to forward from the W/R stages; otherwise same-address requests stall.
module stdp_weight_rmw_ctrl #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 4,
  parameter int W_MAX      = 2**(DATA_WIDTH-1)-1,
  parameter int W_MIN      = -(2**(DATA_WIDTH-1))
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic signed [DATA_WIDTH-1:0] req_delta,
  output logic [ADDR_WIDTH-1:0]        ram_read_addr,
  input  logic signed [DATA_WIDTH-1:0] ram_data_out,
  output logic [ADDR_WIDTH-1:0]        ram_write_addr,
  output logic signed [DATA_WIDTH-1:0] ram_data_in,
  output logic                         ram_we,
  output logic                         done_valid,
  output logic [ADDR_WIDTH-1:0]        done_addr,
  output logic signed [DATA_WIDTH-1:0] done_weight,
  output logic                         done_sat,
  output logic                         busy
);

  localparam logic signed [DATA_WIDTH:0] W_MAX_X = (DATA_WIDTH+1)'(W_MAX);
  localparam logic signed [DATA_WIDTH:0] W_MIN_X = (DATA_WIDTH+1)'(W_MIN);

  // Returns {clamped, value}: the sum is formed one bit wider so it can never wrap.
  function automatic logic [DATA_WIDTH:0] sat_add(
    input logic signed [DATA_WIDTH-1:0] base,
    input logic signed [DATA_WIDTH-1:0] delta
  );
    logic signed [DATA_WIDTH:0] sum;
    sum = $signed({base[DATA_WIDTH-1], base}) + $signed({delta[DATA_WIDTH-1], delta});
    if (sum > W_MAX_X) begin
      sat_add = {1'b1, W_MAX_X[DATA_WIDTH-1:0]};
    end else if (sum < W_MIN_X) begin
      sat_add = {1'b1, W_MIN_X[DATA_WIDTH-1:0]};
    end else begin
      sat_add = {1'b0, sum[DATA_WIDTH-1:0]};
    end
  endfunction

  logic                         accept_s;
  logic signed [DATA_WIDTH-1:0] base_s;

  logic                         v1_q, v1_d;
  logic [ADDR_WIDTH-1:0]        a1_q, a1_d;
  logic signed [DATA_WIDTH-1:0] d1_q, d1_d;

  logic                         v2_q, v2_d;
  logic [ADDR_WIDTH-1:0]        a2_q, a2_d;
  logic signed [DATA_WIDTH-1:0] w2_q, w2_d;
  logic                         s2_q, s2_d;

`ifdef STDP_RMW_FWD_EN
  logic                         vr_q, vr_d;
  logic [ADDR_WIDTH-1:0]        ar_q, ar_d;
  logic signed [DATA_WIDTH-1:0] wr_q, wr_d;
`endif

  // Request handshake, RAM read port and reset-gated result outputs
  always_comb begin
    req_ready      = 1'b0;
    accept_s       = 1'b0;
    ram_read_addr  = '0;
    ram_we         = 1'b0;
    ram_write_addr = '0;
    ram_data_in    = '0;
    done_valid     = 1'b0;
    done_addr      = '0;
    done_weight    = '0;
    done_sat       = 1'b0;
    busy           = 1'b0;
`ifdef STDP_RMW_FWD_EN
    req_ready = ~rst;
`else
    // Without forwarding a read must not overtake a pending write to the same word.
    req_ready = ~rst & ~(v1_q && (req_addr == a1_q)) & ~(v2_q && (req_addr == a2_q));
`endif
    accept_s = req_valid & req_ready;
    if (accept_s) begin
      ram_read_addr = req_addr;
    end else begin
      ram_read_addr = '0;
    end
    if (rst) begin
      ram_we     = 1'b0;
      done_valid = 1'b0;
      busy       = 1'b0;
    end else begin
      ram_we         = v2_q;
      ram_write_addr = a2_q;
      ram_data_in    = w2_q;
      done_valid     = v2_q;
      done_addr      = a2_q;
      done_weight    = w2_q;
      done_sat       = s2_q;
      busy           = v1_q | v2_q;
    end
  end

  // Pipeline next-state: capture request, select base weight, saturate, retire
  always_comb begin
    v1_d = accept_s;
    if (accept_s) begin
      a1_d = req_addr;
      d1_d = req_delta;
    end else begin
      a1_d = a1_q;
      d1_d = d1_q;
    end

`ifdef STDP_RMW_FWD_EN
    if (v2_q && (a2_q == a1_q)) begin
      base_s = w2_q;
    end else if (vr_q && (ar_q == a1_q)) begin
      base_s = wr_q;
    end else begin
      base_s = ram_data_out;
    end
    vr_d = v2_q;
    ar_d = a2_q;
    wr_d = w2_q;
`else
    base_s = ram_data_out;
`endif

    v2_d         = v1_q;
    a2_d         = a1_q;
    {s2_d, w2_d} = sat_add(base_s, d1_q);
  end

  // Pipeline registers; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      a1_q <= '0;
      d1_q <= '0;
      v2_q <= 1'b0;
      a2_q <= '0;
      w2_q <= '0;
      s2_q <= 1'b0;
`ifdef STDP_RMW_FWD_EN
      vr_q <= 1'b0;
      ar_q <= '0;
      wr_q <= '0;
`endif
    end else begin
      v1_q <= v1_d;
      a1_q <= a1_d;
      d1_q <= d1_d;
      v2_q <= v2_d;
      a2_q <= a2_d;
      w2_q <= w2_d;
      s2_q <= s2_d;
`ifdef STDP_RMW_FWD_EN
      vr_q <= vr_d;
      ar_q <= ar_d;
      wr_q <= wr_d;
`endif
    end
  end

endmodule

// File: tb/tb_stdp_weight_rmw_ctrl.sv
// Directed bench for stdp_weight_rmw_ctrl with a behavioural registered-read weight RAM.
module tb_stdp_weight_rmw_ctrl;

  localparam logic signed [19:0] WMAX = 20'sh7FFFF;
  localparam logic signed [19:0] WMIN = 20'sh80000;
`ifdef STDP_RMW_FWD_EN
  localparam int EXP_STALL_SAME = 0;
  localparam int EXP_GAP_SAME   = 1;
  localparam int EXP_STALL_ABA  = 0;
`else
  localparam int EXP_STALL_SAME = 2;
  localparam int EXP_GAP_SAME   = 3;
  localparam int EXP_STALL_ABA  = 1;
`endif

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_addr;
  logic signed [19:0] req_delta;
  logic [3:0]        ram_read_addr;
  logic signed [19:0] ram_data_out;
  logic [3:0]        ram_write_addr;
  logic signed [19:0] ram_data_in;
  logic              ram_we;
  logic              done_valid;
  logic [3:0]        done_addr;
  logic signed [19:0] done_weight;
  logic              done_sat;
  logic              busy;

  logic              pl_we;
  logic [3:0]        pl_addr;
  logic signed [19:0] pl_data;
  logic signed [19:0] mem [16];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wcnt = 0;
  int acnt = 0;
  int acyc [64];
  int wcyc [64];
  logic               wwe    [64];
  logic [3:0]         waddr  [64];
  logic signed [19:0] wdata  [64];
  logic               wdv    [64];
  logic [3:0]         wdaddr [64];
  logic signed [19:0] wdw    [64];
  logic               wds    [64];

  stdp_weight_rmw_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_delta(req_delta),
    .ram_read_addr(ram_read_addr), .ram_data_out(ram_data_out),
    .ram_write_addr(ram_write_addr), .ram_data_in(ram_data_in), .ram_we(ram_we),
    .done_valid(done_valid), .done_addr(done_addr), .done_weight(done_weight),
    .done_sat(done_sat), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Weight RAM: registered read, write on edge, same-edge read returns old data
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_write_addr] <= ram_data_in;
    ram_data_out <= mem[ram_read_addr];
  end

  // Log accepts and write/done events with their cycle numbers
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready && acnt < 64) begin
      acyc[acnt] <= cyc;
      acnt <= acnt + 1;
    end
    if ((ram_we || done_valid) && wcnt < 64) begin
      wcyc[wcnt]   <= cyc;
      wwe[wcnt]    <= ram_we;
      waddr[wcnt]  <= ram_write_addr;
      wdata[wcnt]  <= ram_data_in;
      wdv[wcnt]    <= done_valid;
      wdaddr[wcnt] <= done_addr;
      wdw[wcnt]    <= done_weight;
      wds[wcnt]    <= done_sat;
      wcnt <= wcnt + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_write(input int idx, input int a, input int w, input int s);
    chk($sformatf("w%0d_we", idx), int'(wwe[idx]), 1);
    chk($sformatf("w%0d_addr", idx), int'(waddr[idx]), a);
    chk($sformatf("w%0d_data", idx), int'(wdata[idx]), w);
    chk($sformatf("w%0d_done_valid", idx), int'(wdv[idx]), 1);
    chk($sformatf("w%0d_done_addr", idx), int'(wdaddr[idx]), a);
    chk($sformatf("w%0d_done_weight", idx), int'(wdw[idx]), w);
    chk($sformatf("w%0d_done_sat", idx), int'(wds[idx]), s);
  endtask

  task automatic send(input logic [3:0] a, input logic signed [19:0] d, output int stalls);
    req_valid = 1'b1;
    req_addr  = a;
    req_delta = d;
    stalls    = 0;
    #1;
    while (!req_ready && stalls < 20) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    chk("send_ready", int'(req_ready), 1);
    chk("send_read_addr", int'(ram_read_addr), int'(a));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic signed [19:0] init_w(input int i);
    case (i)
      1:       init_w = 20'sd10;
      3:       init_w = 20'sd100;
      4:       init_w = 20'sd20;
      5:       init_w = WMAX - 20'sd10;
      6:       init_w = WMIN + 20'sd5;
      7:       init_w = 20'sd50;
      8:       init_w = -20'sd7;
      default: init_w = 20'sd0;
    endcase
  endfunction

  initial begin
    int s0, s1, s2;
    rst = 1'b1; req_valid = 1'b1; req_addr = 4'd5; req_delta = 20'sd1;
    pl_we = 1'b0; pl_addr = 4'd0; pl_data = 20'sd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_read_addr", int'(ram_read_addr), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_done_valid", int'(done_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done_weight", int'(done_weight), 0);
    req_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pl_we = 1'b1; pl_addr = 4'(i); pl_data = init_w(i);
      @(negedge clk);
    end
    pl_we = 1'b0;

    // Single update, issued in the first cycle after reset deasserts
    rst = 1'b0;
    send(4'd3, 20'sd25, s0);
    chk("first_cycle_stall", s0, 0);
    req_valid = 1'b0;
    #1 chk("busy_e", int'(busy), 1);
    @(negedge clk);
    #1 chk("busy_w", int'(busy), 1);
    chk("live_ram_data_in", int'(ram_data_in), 125);
    idle(3);
    req_addr = 4'd9;
    #1 chk("idle_read_addr", int'(ram_read_addr), 0);
    chk("wcnt_1", wcnt, 1);
    chk_write(0, 3, 125, 0);
    chk("latency", wcyc[0] - acyc[0], 2);
    chk("mem3", int'(mem[3]), 125);
    chk("busy_idle", int'(busy), 0);

    // Saturation at both bounds
    send(4'd5, 20'sd50, s0);
    send(4'd6, -20'sd20, s1);
    idle(4);
    chk("wcnt_3", wcnt, 3);
    chk_write(1, 5, int'(WMAX), 1);
    chk_write(2, 6, int'(WMIN), 1);
    chk("mem5", int'(mem[5]), int'(WMAX));
    chk("mem6", int'(mem[6]), int'(WMIN));

    // Back-to-back same address
    send(4'd2, 20'sd1, s0);
    send(4'd2, 20'sd2, s1);
    send(4'd2, 20'sd4, s2);
    idle(6);
    chk("same_stall1", s1, EXP_STALL_SAME);
    chk("same_stall2", s2, EXP_STALL_SAME);
    chk("wcnt_6", wcnt, 6);
    chk_write(3, 2, 1, 0);
    chk_write(4, 2, 3, 0);
    chk_write(5, 2, 7, 0);
    chk("same_gap1", wcyc[4] - wcyc[3], EXP_GAP_SAME);
    chk("same_gap2", wcyc[5] - wcyc[4], EXP_GAP_SAME);
    chk("mem2", int'(mem[2]), 7);

    // A,B,A pattern
    send(4'd1, 20'sd5, s0);
    send(4'd4, 20'sd5, s1);
    send(4'd1, 20'sd5, s2);
    idle(6);
    chk("aba_stall_b", s1, 0);
    chk("aba_stall_a", s2, EXP_STALL_ABA);
    chk("wcnt_9", wcnt, 9);
    chk_write(6, 1, 15, 0);
    chk_write(7, 4, 25, 0);
    chk_write(8, 1, 20, 0);
    chk("mem1", int'(mem[1]), 20);
    chk("mem4", int'(mem[4]), 25);

    // Reset while an update is in flight
    req_valid = 1'b1; req_addr = 4'd7; req_delta = 20'sd3;
    #1 chk("pre_rst_ready", int'(req_ready), 1);
    @(negedge clk);
    rst = 1'b1; req_addr = 4'd8;
    #1;
    chk("inrst_ready", int'(req_ready), 0);
    chk("inrst_read_addr", int'(ram_read_addr), 0);
    chk("inrst_busy", int'(busy), 0);
    chk("inrst_ram_we", int'(ram_we), 0);
    @(negedge clk);
    #1;
    chk("postrst_ram_we", int'(ram_we), 0);
    chk("postrst_done_valid", int'(done_valid), 0);
    chk("postrst_done_addr", int'(done_addr), 0);
    chk("postrst_done_sat", int'(done_sat), 0);
    chk("postrst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    chk("rst_no_write", wcnt, 9);
    chk("mem7", int'(mem[7]), 50);
    chk("mem8", int'(mem[8]), -7);
    chk("final_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
